// File: rtl/alu_cmd_pkg.sv
// Shared EX-stage definitions: ALU EXE_CMD encodings, status-register bit
// positions and the MUL sequencer state encoding.
package alu_cmd_pkg;

  // ALU EXE_CMD encodings
  localparam logic [3:0] EXE_NOP = 4'h0;
  localparam logic [3:0] EXE_MOV = 4'h1;
  localparam logic [3:0] EXE_ADD = 4'h2;
  localparam logic [3:0] EXE_MVN = 4'h9;

  // Status register bit positions within {N,Z,C,V}
  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // New {N,Z,C,V}: N and Z from the product, C and V carried over from sr.
  function automatic logic [3:0] mul_flags(input logic msb, input logic zero,
                                           input logic [3:0] sr);
    logic [3:0] f;
    f       = sr & 4'b0011;
    f[SR_N] = msb;
    f[SR_Z] = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle 32-bit MUL (low word) built from shift-add
// iterations on the shared EX-stage ALU. While running it owns the ALU inputs
// (alu_sel) and stalls the pipeline; the product and optional {N,Z,C,V}
// update are presented for one cycle with done.
// Optional feature macro: MUL_EARLY_EXIT_EN -- finish as soon as no set
// multiplier bits remain instead of always iterating WIDTH times.
module alu_mul_sequencer
  import alu_cmd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             set_s,
  input  logic [3:0]       sr_in,
  input  logic [WIDTH-1:0] alu_result,
  output logic             alu_sel,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_cmd,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             sr_we,
  output logic [3:0]       sr_out
);

  mul_state_e       state_q, state_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             s_q;
  logic [WIDTH-1:0] product_q;
  logic [3:0]       sr_out_q;
  logic             last_iter;

  // Last RUN iteration: fixed count, or optionally no multiplier bits left
  always_comb begin
`ifdef MUL_EARLY_EXIT_EN
    last_iter = (count_q == CNT_W'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
    last_iter = (count_q == CNT_W'(WIDTH - 1));
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and ALU/pipeline control outputs
  always_comb begin
    state_d = state_q;
    alu_sel = 1'b0;
    alu_in1 = '0;
    alu_in2 = '0;
    alu_cmd = EXE_NOP;
    stall   = 1'b0;
    done    = 1'b0;
    sr_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // hold the issuing instruction in EX the same cycle start is seen
        stall = start;
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        alu_sel = 1'b1;
        alu_in1 = mcand_q;
        alu_in2 = acc_q;
        // MOV passes the accumulator through unchanged when the bit is 0
        alu_cmd = mplier_q[0] ? EXE_ADD : EXE_MOV;
        stall   = 1'b1;
        if (last_iter) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        sr_we   = s_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand capture, shift-add datapath and result/flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      s_q       <= 1'b0;
      product_q <= '0;
      sr_out_q  <= 4'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            s_q      <= set_s;
            acc_q    <= '0;
            count_q  <= '0;
          end
        end
        ST_RUN: begin
          acc_q    <= alu_result;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CNT_W'(1);
          if (last_iter) begin
            // ADD carry-out is simply dropped: product is mod 2**WIDTH
            product_q <= alu_result;
            sr_out_q  <= mul_flags(alu_result[WIDTH-1], alu_result == '0, sr_in);
          end
        end
        default: begin
          acc_q <= acc_q;
        end
      endcase
    end
  end

  assign product = product_q;
  assign sr_out  = sr_out_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed self-checking bench for alu_mul_sequencer with a behavioural
// EX-stage ALU closing the alu_in/alu_result loop.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        set_s;
  logic [3:0]  sr_in;
  logic [31:0] alu_result;
  logic        alu_sel;
  logic [31:0] alu_in1, alu_in2;
  logic [3:0]  alu_cmd;
  logic        stall, done, sr_we;
  logic [31:0] product;
  logic [3:0]  sr_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: MOV passes in2, ADD adds, MVN inverts in2
  always_comb begin
    case (alu_cmd)
      4'h1:    alu_result = alu_in2;
      4'h2:    alu_result = alu_in1 + alu_in2;
      4'h9:    alu_result = ~alu_in2;
      default: alu_result = 32'h0;
    endcase
  end

  alu_mul_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .set_s(set_s), .sr_in(sr_in), .alu_result(alu_result),
    .alu_sel(alu_sel), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_cmd(alu_cmd), .stall(stall), .done(done), .product(product),
    .sr_we(sr_we), .sr_out(sr_out)
  );

  // Launch one MUL at cycle 0 and observe 50 cycles; cycle numbers count
  // clock edges after the start-sampling edge.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [3:0] sr, input logic keep_start,
                         output int dcyc, output logic [31:0] prod,
                         output logic we, output logic [3:0] sro,
                         output int stall_bad, output int ndone);
    @(negedge clk);
    op_a = a; op_b = b; set_s = s; sr_in = sr; start = 1'b1;
    dcyc = -1; ndone = 0; stall_bad = 0; prod = 32'h0; we = 1'b0; sro = 4'h0;
    #1;
    if (stall !== 1'b1) stall_bad++;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start = keep_start && (dcyc < 0);
      if (keep_start) begin
        op_a = ~a; op_b = b ^ 32'h0000_0005; set_s = ~s;
      end
      #1;
      if (done === 1'b1) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc = c; prod = product; we = sr_we; sro = sr_out;
          if (stall !== 1'b0 || alu_sel !== 1'b0 || alu_cmd !== 4'h0) stall_bad++;
        end
      end else if (dcyc < 0) begin
        if (stall !== 1'b1 || alu_sel !== 1'b1) stall_bad++;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_a = 32'h0; op_b = 32'h0; set_s = 1'b0; sr_in = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({alu_sel, stall, done, sr_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {alu_sel, stall, done, sr_we});
    end
    checks++;
    if (product !== 32'h0 || sr_out !== 4'h0 || alu_cmd !== 4'h0 || alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin
      errors++; $display("FAIL reset_data: product %h sr_out %h cmd %h expected all zero", product, sr_out, alu_cmd);
    end
  endtask

  task automatic test_basic_mul();
    int d, sb, nd; logic [31:0] p; logic w; logic [3:0] so; int lat;
`ifdef MUL_EARLY_EXIT_EN
    lat = 4;
`else
    lat = 33;
`endif
    run_mul(32'd6, 32'd7, 1'b1, 4'b0011, 1'b0, d, p, w, so, sb, nd);
    checks++; if (d != lat) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", d, lat); end
    checks++; if (p !== 32'd42) begin errors++; $display("FAIL basic_product: got %0d expected 42", p); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL basic_sr_we: got %b expected 1", w); end
    checks++; if (so !== 4'b0011) begin errors++; $display("FAIL basic_sr_out: got %b expected 0011", so); end
    checks++; if (sb != 0) begin errors++; $display("FAIL basic_stall_alu_sel: got %0d bad cycles expected 0", sb); end
  endtask

  task automatic test_negative_flag();
    int d, sb, nd; logic [31:0] p; logic w; logic [3:0] so; int lat;
`ifdef MUL_EARLY_EXIT_EN
    lat = 3;
`else
    lat = 33;
`endif
    run_mul(32'hFFFF_FFFF, 32'd2, 1'b1, 4'b0000, 1'b0, d, p, w, so, sb, nd);
    checks++; if (d != lat) begin errors++; $display("FAIL neg_latency: got %0d expected %0d", d, lat); end
    checks++; if (p !== 32'hFFFF_FFFE) begin errors++; $display("FAIL neg_product: got %h expected fffffffe", p); end
    checks++; if (so !== 4'b1000 || w !== 1'b1) begin errors++; $display("FAIL neg_flags: got sr_out %b we %b expected 1000 1", so, w); end
  endtask

  task automatic test_zero_no_s();
    int d, sb, nd; logic [31:0] p; logic w; logic [3:0] so; int lat;
`ifdef MUL_EARLY_EXIT_EN
    lat = 2;
`else
    lat = 33;
`endif
    run_mul(32'h1234_5678, 32'd0, 1'b0, 4'b0110, 1'b0, d, p, w, so, sb, nd);
    checks++; if (d != lat) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", d, lat); end
    checks++; if (p !== 32'h0) begin errors++; $display("FAIL zero_product: got %h expected 0", p); end
    checks++; if (w !== 1'b0) begin errors++; $display("FAIL zero_sr_we: got %b expected 0", w); end
    checks++; if (sb != 0) begin errors++; $display("FAIL zero_stall: got %0d bad cycles expected 0", sb); end
  endtask

  task automatic test_back_to_back();
    int d, sb, nd; logic [31:0] p; logic w; logic [3:0] so;
    run_mul(32'd6, 32'd7, 1'b1, 4'b0011, 1'b1, d, p, w, so, sb, nd);
    checks++; if (nd != 1) begin errors++; $display("FAIL b2b_done_count: got %0d expected 1", nd); end
    checks++; if (p !== 32'd42) begin errors++; $display("FAIL b2b_product: got %0d expected 42", p); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL b2b_sr_we: got %b expected 1", w); end
    checks++; if (product !== 32'd42) begin errors++; $display("FAIL b2b_product_held: got %0d expected 42", product); end
  endtask

  task automatic test_reset_mid_run();
    int d, sb, nd; logic [31:0] p; logic w; logic [3:0] so; int lat; int extra;
`ifdef MUL_EARLY_EXIT_EN
    lat = 5;
`else
    lat = 33;
`endif
    @(negedge clk);
    op_a = 32'd3; op_b = 32'h8000_0003; set_s = 1'b1; sr_in = 4'h0; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, alu_sel, done, sr_we} !== 4'b0000) begin
      errors++; $display("FAIL rst_mid_ctrl: got %b expected 0000", {stall, alu_sel, done, sr_we});
    end
    checks++; if (product !== 32'h0) begin errors++; $display("FAIL rst_mid_product: got %h expected 0", product); end
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (done === 1'b1 || stall === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", extra); end
    run_mul(32'd9, 32'd11, 1'b0, 4'h0, 1'b0, d, p, w, so, sb, nd);
    checks++; if (d != lat || p !== 32'd99) begin errors++; $display("FAIL rst_mid_restart: got cycle %0d product %0d expected %0d 99", d, p, lat); end
  endtask

  task automatic test_early_exit();
    int d, sb, nd; logic [31:0] p; logic w; logic [3:0] so; int lat5, lat0;
`ifdef MUL_EARLY_EXIT_EN
    lat5 = 4; lat0 = 2;
`else
    lat5 = 33; lat0 = 33;
`endif
    run_mul(32'd3, 32'd5, 1'b1, 4'b0001, 1'b0, d, p, w, so, sb, nd);
    checks++; if (d != lat5 || p !== 32'd15) begin errors++; $display("FAIL exit_3x5: got cycle %0d product %0d expected %0d 15", d, p, lat5); end
    checks++; if (so !== 4'b0001) begin errors++; $display("FAIL exit_3x5_flags: got %b expected 0001", so); end
    run_mul(32'd77, 32'd0, 1'b1, 4'b0010, 1'b0, d, p, w, so, sb, nd);
    checks++; if (d != lat0 || p !== 32'd0) begin errors++; $display("FAIL exit_zero: got cycle %0d product %0d expected %0d 0", d, p, lat0); end
    checks++; if (so !== 4'b0110 || w !== 1'b1) begin errors++; $display("FAIL exit_zero_flags: got %b we %b expected 0110 1", so, w); end
  endtask

  initial begin
    test_reset();
    test_basic_mul();
    test_negative_flag();
    test_zero_no_s();
    test_back_to_back();
    test_reset_mid_run();
    test_early_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
